// File: rtl/seven_segment_scanner_if.sv
// Connection between the I/O register file and the seven-segment scanner:
// display data and masks flow in, multiplexed pin drives flow out.
interface seven_segment_scanner_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   en_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    lz_blank;
  logic                    load;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output value, dp_mask, en_mask, blink_mask, lz_blank, load,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  value, dp_mask, en_mask, blink_mask, lz_blank, load,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode seven-segment driver with guard cycle,
// blink, leading-zero blanking and frame-aligned double buffering.
module seven_segment_scanner #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input logic                    clk,
  input logic                    rst_n,
  seven_segment_scanner_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_FRAMES - 1);
  localparam logic [BW-1:0] BLK_ONE = BW'(1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BW-1:0]         blk_q, blk_d;
  logic                  ph_q, ph_d;
  logic [VW-1:0]         sh_value_q, sh_value_d, ac_value_q, ac_value_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d, ac_dp_q, ac_dp_d;
  logic [NUM_DIGITS-1:0] sh_en_q, sh_en_d, ac_en_q, ac_en_d;
  logic [NUM_DIGITS-1:0] sh_blink_q, sh_blink_d, ac_blink_q, ac_blink_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  logic                  wrap_s, boundary_s;
  logic [3:0]            nib_s;
  logic                  dp_bit_s, en_bit_s, blink_bit_s;
  logic                  hi_zero_s, lz_hit_s, blank_s;
  logic [NUM_DIGITS-1:0] sel_s;

  // Scan counters, double buffer and blink phase next-state
  always_comb begin
    wrap_s     = (cnt_q == CNT_MAX);
    boundary_s = wrap_s && (idx_q == IDX_MAX);
    cnt_d      = wrap_s ? {CW{1'b0}} : (cnt_q + CNT_ONE);
    if (wrap_s) begin
      idx_d = (idx_q == IDX_MAX) ? {IW{1'b0}} : (idx_q + IDX_ONE);
    end else begin
      idx_d = idx_q;
    end
    if (bus.load) begin
      sh_value_d = bus.value;
      sh_dp_d    = bus.dp_mask;
      sh_en_d    = bus.en_mask;
      sh_blink_d = bus.blink_mask;
    end else begin
      sh_value_d = sh_value_q;
      sh_dp_d    = sh_dp_q;
      sh_en_d    = sh_en_q;
      sh_blink_d = sh_blink_q;
    end
    // Active set only changes at the frame boundary, so a frame is never mixed
    if (boundary_s) begin
      ac_value_d = sh_value_q;
      ac_dp_d    = sh_dp_q;
      ac_en_d    = sh_en_q;
      ac_blink_d = sh_blink_q;
    end else begin
      ac_value_d = ac_value_q;
      ac_dp_d    = ac_dp_q;
      ac_en_d    = ac_en_q;
      ac_blink_d = ac_blink_q;
    end
    if (boundary_s) begin
      blk_d = (blk_q == BLK_MAX) ? {BW{1'b0}} : (blk_q + BLK_ONE);
      ph_d  = (blk_q == BLK_MAX) ? ~ph_q : ph_q;
    end else begin
      blk_d = blk_q;
      ph_d  = ph_q;
    end
    frame_done_d = boundary_s;
  end

  // Select the current digit and decode the pin drive for the next cycle
  always_comb begin
    nib_s       = 4'h0;
    dp_bit_s    = 1'b0;
    en_bit_s    = 1'b0;
    blink_bit_s = 1'b0;
    hi_zero_s   = 1'b1;
    lz_hit_s    = 1'b0;
    sel_s       = {NUM_DIGITS{1'b0}};
    // Walk from the top digit down so hi_zero_s covers this nibble and all above
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      hi_zero_s = hi_zero_s && (ac_value_q[4*i +: 4] == 4'h0);
      if (idx_q == IW'(i)) begin
        sel_s[i]    = 1'b1;
        nib_s       = ac_value_q[4*i +: 4];
        dp_bit_s    = ac_dp_q[i];
        en_bit_s    = ac_en_q[i];
        blink_bit_s = ac_blink_q[i];
        lz_hit_s    = bus.lz_blank && (i != 0) && hi_zero_s;
      end else begin
        sel_s[i] = 1'b0;
      end
    end
    blank_s = (ph_q && blink_bit_s) || lz_hit_s;
    if (wrap_s || !en_bit_s) begin
      an_d  = {NUM_DIGITS{1'b1}};
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end else begin
      an_d  = ~sel_s;
      seg_d = blank_s ? 7'h7F : hex_to_seg(nib_s);
      dp_d  = blank_s ? 1'b1 : ~dp_bit_s;
    end
  end

  // All state and registered pin drives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= {CW{1'b0}};
      idx_q        <= {IW{1'b0}};
      blk_q        <= {BW{1'b0}};
      ph_q         <= 1'b0;
      sh_value_q   <= {VW{1'b0}};
      sh_dp_q      <= {NUM_DIGITS{1'b0}};
      sh_en_q      <= {NUM_DIGITS{1'b0}};
      sh_blink_q   <= {NUM_DIGITS{1'b0}};
      ac_value_q   <= {VW{1'b0}};
      ac_dp_q      <= {NUM_DIGITS{1'b0}};
      ac_en_q      <= {NUM_DIGITS{1'b0}};
      ac_blink_q   <= {NUM_DIGITS{1'b0}};
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= {NUM_DIGITS{1'b1}};
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      blk_q        <= blk_d;
      ph_q         <= ph_d;
      sh_value_q   <= sh_value_d;
      sh_dp_q      <= sh_dp_d;
      sh_en_q      <= sh_en_d;
      sh_blink_q   <= sh_blink_d;
      ac_value_q   <= ac_value_d;
      ac_dp_q      <= ac_dp_d;
      ac_en_q      <= ac_en_d;
      ac_blink_q   <= ac_blink_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner: 4 digits, 4-cycle dwell, 2-frame blink.
module tb_seven_segment_scanner;
  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  seven_segment_scanner_if #(.NUM_DIGITS(ND)) bus ();

  seven_segment_scanner #(
    .NUM_DIGITS(ND), .REFRESH_DIV(4), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] value;
    logic [3:0]  dp_m;
    logic [3:0]  en_m;
    logic        lz;
    logic [27:0] exp_seg;
    logic [3:0]  exp_dp;
  } vec_t;

  vec_t vecs[10];
  logic [3:0] seq_an[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (cyc %0d): got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input logic [15:0] v, input logic [3:0] dpm, input logic [3:0] enm,
                       input logic [3:0] blm, input logic lz);
    bus.value      = v;
    bus.dp_mask    = dpm;
    bus.en_mask    = enm;
    bus.blink_mask = blm;
    bus.lz_blank   = lz;
  endtask

  task automatic pulse_load();
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    step();
    while (bus.frame_done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({name, "_frame_wait"}, 32'(bus.frame_done), 32'd1);
  endtask

  task automatic apply_vec(input vec_t v);
    logic [3:0] one4;
    logic [3:0] exp_an;
    int d;
    one4 = 4'b0001;
    drive(v.value, v.dp_m, v.en_m, 4'h0, v.lz);
    pulse_load();
    wait_frame(v.name);
    for (int s = 0; s < 16; s++) begin
      step();
      if (s % 4 == 1) begin
        d = s / 4;
        exp_an = v.en_m[d] ? ~(one4 << d) : 4'hF;
        chk({v.name, "_seg"}, 32'(bus.seg), 32'(v.exp_seg[7*d +: 7]));
        chk({v.name, "_dp"},  32'(bus.dp),  32'(v.exp_dp[d]));
        chk({v.name, "_an"},  32'(bus.an),  32'(exp_an));
      end
    end
  endtask

  initial begin
    logic lit2;
    int   f;

    vecs[0] = '{"dec_3210", 16'h3210, 4'h0, 4'hF, 1'b0, {7'h30, 7'h24, 7'h79, 7'h40}, 4'hF};
    vecs[1] = '{"dec_fedc", 16'hFEDC, 4'h0, 4'hF, 1'b0, {7'h0E, 7'h06, 7'h21, 7'h46}, 4'hF};
    vecs[2] = '{"dec_7654", 16'h7654, 4'h0, 4'hF, 1'b0, {7'h78, 7'h02, 7'h12, 7'h19}, 4'hF};
    vecs[3] = '{"dec_ba98", 16'hBA98, 4'h0, 4'hF, 1'b0, {7'h03, 7'h08, 7'h10, 7'h00}, 4'hF};
    vecs[4] = '{"lz_on_0050", 16'h0050, 4'h0, 4'hF, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF};
    vecs[5] = '{"lz_off_0050", 16'h0050, 4'h0, 4'hF, 1'b0, {7'h40, 7'h40, 7'h12, 7'h40}, 4'hF};
    vecs[6] = '{"dp_1234", 16'h1234, 4'b0100, 4'hF, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1011};
    vecs[7] = '{"en_8888", 16'h8888, 4'h0, 4'b1011, 1'b0, {7'h00, 7'h7F, 7'h00, 7'h00}, 4'hF};
    vecs[8] = '{"lz_0000_dp", 16'h0000, 4'hF, 4'hF, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1110};
    vecs[9] = '{"lz_0100_dp", 16'h0100, 4'hF, 4'hF, 1'b1, {7'h7F, 7'h79, 7'h40, 7'h40}, 4'b1000};
    seq_an = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
               4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};

    bus.load = 1'b0;
    drive(16'h0000, 4'h0, 4'h0, 4'h0, 1'b0);

    // Reset state
    @(negedge clk);
    chk("rst_seg", 32'(bus.seg), 32'h7F);
    chk("rst_dp",  32'(bus.dp),  32'd1);
    chk("rst_an",  32'(bus.an),  32'hF);
    chk("rst_fd",  32'(bus.frame_done), 32'd0);
    rst_n = 1'b1;
    cyc = 0;

    // Blink and enable: frame count runs from reset release
    drive(16'h1111, 4'h0, 4'b1011, 4'b0001, 1'b0);
    pulse_load();
    lit2 = 1'b0;
    while (cyc < 96) begin
      step();
      chk("blink_fd", 32'(bus.frame_done), 32'((cyc % 16) == 0));
      if (bus.an[2] === 1'b0) lit2 = 1'b1;
      if (cyc % 16 == 2) begin
        f = cyc / 16;
        if (f == 0) begin
          chk("blink_f0_an",  32'(bus.an),  32'hF);
          chk("blink_f0_seg", 32'(bus.seg), 32'h7F);
        end else begin
          chk("blink_an",  32'(bus.an),  32'hE);
          chk("blink_seg", 32'(bus.seg), (f == 2 || f == 3) ? 32'h7F : 32'h79);
        end
      end
    end
    chk("blink_digit2_never_lit", 32'(lit2), 32'd0);

    // Anode sequence with guard cycles over one full frame
    drive(16'h0000, 4'h0, 4'hF, 4'h0, 1'b0);
    pulse_load();
    wait_frame("seq");
    for (int s = 0; s < 16; s++) begin
      step();
      chk("seq_an", 32'(bus.an), 32'(seq_an[s]));
      chk("seq_fd", 32'(bus.frame_done), 32'(s == 15));
    end

    for (int i = 0; i < 10; i++) apply_vec(vecs[i]);

    // dp follows digit 2 only
    drive(16'h1111, 4'b0100, 4'hF, 4'h0, 1'b0);
    pulse_load();
    wait_frame("dpchk");
    for (int s = 0; s < 16; s++) begin
      step();
      chk("dp_only_digit2", 32'(bus.dp), 32'(!((s / 4 == 2) && (s % 4 != 3))));
    end
    // Load landing exactly on the boundary edge shows one frame later
    repeat (15) step();
    drive(16'h2222, 4'b0100, 4'hF, 4'h0, 1'b0);
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    chk("coll_on_boundary", 32'(bus.frame_done), 32'd1);
    for (int s = 0; s < 16; s++) begin
      step();
      if (s == 1) chk("coll_old_seg", 32'(bus.seg), 32'h79);
    end
    chk("coll_fd", 32'(bus.frame_done), 32'd1);
    step();
    step();
    chk("coll_new_seg", 32'(bus.seg), 32'h24);
    chk("coll_new_an",  32'(bus.an),  32'hE);

    // Async reset with cnt=2, idx=2
    repeat (8) step();
    chk("pre_rst_an", 32'(bus.an), 32'hB);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seg", 32'(bus.seg), 32'h7F);
    chk("arst_dp",  32'(bus.dp),  32'd1);
    chk("arst_an",  32'(bus.an),  32'hF);
    chk("arst_fd",  32'(bus.frame_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < 32) begin
      step();
      chk("arst_restart_fd", 32'(bus.frame_done), 32'((cyc % 16) == 0));
      if (cyc % 4 == 2) begin
        chk("arst_active0_an",  32'(bus.an),  32'hF);
        chk("arst_active0_seg", 32'(bus.seg), 32'h7F);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
